instruction_register: RTL and testbench



---
 rtl/instruction_register_pkg.sv | 30 +++
 rtl/instruction_register.sv | 48 ++++
 tb/tb_instruction_register.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/instruction_register_pkg.sv
// Instruction word layout shared by the instruction register and the decoder.
package instruction_register_pkg;

    localparam int unsigned WORD_W = 32;

    localparam int unsigned OPCODE_HI = 31;
    localparam int unsigned OPCODE_LO = 26;
    localparam int unsigned RS_HI     = 25;
    localparam int unsigned RS_LO     = 21;
    localparam int unsigned RT_HI     = 20;
    localparam int unsigned RT_LO     = 16;
    localparam int unsigned RD_HI     = 15;
    localparam int unsigned RD_LO     = 11;
    localparam int unsigned SHAMT_HI  = 10;
    localparam int unsigned SHAMT_LO  = 6;
    localparam int unsigned FUNCT_HI  = 5;
    localparam int unsigned FUNCT_LO  = 0;
    localparam int unsigned IMM_HI    = 15;
    localparam int unsigned IMM_LO    = 0;
    localparam int unsigned TARGET_HI = 25;
    localparam int unsigned TARGET_LO = 0;

    localparam int unsigned IMM_W = IMM_HI - IMM_LO + 1;

    // Replicate the immediate's top bit into the upper half of a data word.
    function automatic logic [WORD_W-1:0] sign_extend_imm(input logic [IMM_W-1:0] imm);
        return {{(WORD_W - IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/instruction_register.sv
// Holds the fetched instruction word and exposes its fields as plain slices.
module instruction_register
    import instruction_register_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WORD_W-1:0] d,
    output logic [5:0]        q31_26,
    output logic [4:0]        q25_21,
    output logic [4:0]        q20_16,
    output logic [15:0]       q15_0,
    output logic [4:0]        q15_11,
    output logic [4:0]        q10_6,
    output logic [5:0]        q5_0,
    output logic [25:0]       q25_0,
    output logic [WORD_W-1:0] imm_sext
);

    logic [WORD_W-1:0] ir_q;
    logic [WORD_W-1:0] ir_d;

    always_comb begin
        ir_d = ir_q;
        if (enable) begin
            ir_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    assign q31_26   = ir_q[OPCODE_HI:OPCODE_LO];
    assign q25_21   = ir_q[RS_HI:RS_LO];
    assign q20_16   = ir_q[RT_HI:RT_LO];
    assign q15_0    = ir_q[IMM_HI:IMM_LO];
    assign q15_11   = ir_q[RD_HI:RD_LO];
    assign q10_6    = ir_q[SHAMT_HI:SHAMT_LO];
    assign q5_0     = ir_q[FUNCT_HI:FUNCT_LO];
    assign q25_0    = ir_q[TARGET_HI:TARGET_LO];
    assign imm_sext = sign_extend_imm(ir_q[IMM_HI:IMM_LO]);

endmodule

// File: tb/tb_instruction_register.sv
// Directed vector bench for instruction_register with hand-computed field values.
module tb_instruction_register;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [25:0] target;
        logic [31:0] sext;
    } fields_t;

    typedef struct {
        string   name;
        logic    rst;
        logic    en;
        logic [31:0] din;
        fields_t exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] d;
    logic [5:0]  q31_26;
    logic [4:0]  q25_21;
    logic [4:0]  q20_16;
    logic [15:0] q15_0;
    logic [4:0]  q15_11;
    logic [4:0]  q10_6;
    logic [5:0]  q5_0;
    logic [25:0] q25_0;
    logic [31:0] imm_sext;

    int applied;
    int miscompares;

    instruction_register dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .d        (d),
        .q31_26   (q31_26),
        .q25_21   (q25_21),
        .q20_16   (q20_16),
        .q15_0    (q15_0),
        .q15_11   (q15_11),
        .q10_6    (q10_6),
        .q5_0     (q5_0),
        .q25_0    (q25_0),
        .imm_sext (imm_sext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam fields_t F_ZERO = '0;
    localparam fields_t F_AF31 = '{op: 6'h2B, rs: 5'h19, rt: 5'h11, imm: 16'hAF31, rd: 5'h15,
                                   shamt: 5'h1C, funct: 6'h31, target: 26'h331AF31,
                                   sext: 32'hFFFFAF31};
    localparam fields_t F_8C22 = '{op: 6'h23, rs: 5'h01, rt: 5'h02, imm: 16'h0004, rd: 5'h00,
                                   shamt: 5'h00, funct: 6'h04, target: 26'h0220004,
                                   sext: 32'h00000004};
    localparam fields_t F_1234 = '{op: 6'h04, rs: 5'h11, rt: 5'h14, imm: 16'h5678, rd: 5'h0A,
                                   shamt: 5'h19, funct: 6'h38, target: 26'h2345678,
                                   sext: 32'h00005678};
    localparam fields_t F_ONES = '{op: 6'h3F, rs: 5'h1F, rt: 5'h1F, imm: 16'hFFFF, rd: 5'h1F,
                                   shamt: 5'h1F, funct: 6'h3F, target: 26'h3FFFFFF,
                                   sext: 32'hFFFFFFFF};

    task automatic check(input string name, input fields_t exp);
        fields_t act;
        act = '{op: q31_26, rs: q25_21, rt: q20_16, imm: q15_0, rd: q15_11, shamt: q10_6,
                funct: q5_0, target: q25_0, sext: imm_sext};
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got op=%h rs=%h rt=%h imm=%h rd=%h sh=%h fn=%h tgt=%h sx=%h, want op=%h rs=%h rt=%h imm=%h rd=%h sh=%h fn=%h tgt=%h sx=%h",
                     name, act.op, act.rs, act.rt, act.imm, act.rd, act.shamt, act.funct,
                     act.target, act.sext, exp.op, exp.rs, exp.rt, exp.imm, exp.rd,
                     exp.shamt, exp.funct, exp.target, exp.sext);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive_and_clock(input logic rst, input logic en, input logic [31:0] din);
        @(negedge clk);
        reset  = rst;
        enable = en;
        d      = din;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        applied     = 0;
        miscompares = 0;
        reset       = 1'b0;
        enable      = 1'b0;
        d           = '0;

        vecs.push_back('{"reset_clear",    1'b0, 1'b1, 32'hAF31AF31, F_ZERO});
        vecs.push_back('{"load_af31",      1'b1, 1'b1, 32'hAF31AF31, F_AF31});
        vecs.push_back('{"hold_1",         1'b1, 1'b0, 32'h00000000, F_AF31});
        vecs.push_back('{"hold_2",         1'b1, 1'b0, 32'h00000000, F_AF31});
        vecs.push_back('{"hold_3",         1'b1, 1'b0, 32'h12345678, F_AF31});
        vecs.push_back('{"load_8c22",      1'b1, 1'b1, 32'h8C220004, F_8C22});
        vecs.push_back('{"b2b_edge1",      1'b1, 1'b1, 32'h12345678, F_1234});
        vecs.push_back('{"b2b_edge2",      1'b1, 1'b1, 32'hFFFFFFFF, F_ONES});
        vecs.push_back('{"reset_over_en",  1'b0, 1'b1, 32'hFFFFFFFF, F_ZERO});
        vecs.push_back('{"reload_after_rst", 1'b1, 1'b1, 32'h12345678, F_1234});

        for (int i = 0; i < vecs.size(); i++) begin
            drive_and_clock(vecs[i].rst, vecs[i].en, vecs[i].din);
            check(vecs[i].name, vecs[i].exp);
        end

        // d wiggling between edges must not reach the outputs.
        drive_and_clock(1'b1, 1'b1, 32'hAF31AF31);
        check("seq_load", F_AF31);
        @(negedge clk);
        enable = 1'b1;
        d      = 32'h8C220004;
        #2;
        check("no_comb_d_path", F_AF31);
        enable = 1'b0;

        // Asynchronous reset between edges clears without a clock.
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_midcycle", F_ZERO);

        // Held in reset with enable high at an edge: still cleared.
        enable = 1'b1;
        d      = 32'hAF31AF31;
        @(posedge clk);
        #1;
        check("reset_blocks_load", F_ZERO);

        // Release between edges: nothing loads until the next rising edge.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_no_edge", F_ZERO);
        @(posedge clk);
        #1;
        check("first_load_after_release", F_AF31);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
